alu_share_arbiter: RTL and testbench

- Shares one instance of the team's 2-bit-opcode decimal ALU (SUM/SUB/MUL/DIV; BCD tens/units; zero/error flags) between NREQ requesters.
- Round-robin grant, valid/ready request and response handshakes, operands registered before the ALU, result registered after it.
- Sits between the requester ports and the shared ALU.

---
 rtl/alu_share_arbiter_pkg.sv | 19 +
 rtl/alu_rr_grant.sv | 31 +++
 rtl/dec_alu.sv | 56 +++++
 rtl/alu_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU-sharing arbiter: opcodes, FSM encoding and
// statistics counter width.
package alu_arb_pkg;

  // Decimal ALU opcodes
  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Width of the optional operation/error counters
  localparam int STAT_W = 8;

endpackage

// File: rtl/alu_rr_grant.sv
// Round-robin grant selection: first valid requester after last_grant,
// wrapping modulo NREQ. Purely combinational.
module alu_rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  // Scan requesters starting just after the previous winner
  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/dec_alu.sv
// Decimal ALU: SUM/SUB/MUL/DIV on unsigned operands, result presented as
// BCD tens/units digits with zero and error flags. Purely combinational.
module dec_alu
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  output logic [3:0]       dec,
  output logic [3:0]       unis,
  output logic             zero,
  output logic             error
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0] result;
  logic          div_by_zero;

  assign div_by_zero = (op == OP_DIV) && (in2 == '0);

  // Compute the binary result, then split it into decimal digits and flags
  always_comb begin
    result = '0;
    error  = 1'b0;
    dec    = 4'd0;
    unis   = 4'd0;
    zero   = 1'b0;
    case (op)
      OP_SUM: result = RW'(in1) + RW'(in2);
      OP_SUB: begin
        // Negative results are not representable: flag and return 0
        if (in1 < in2) error = 1'b1;
        else           result = RW'(in1) - RW'(in2);
      end
      OP_MUL: result = RW'(in1) * RW'(in2);
      default: begin
        if (in2 == '0) error = 1'b1;
        else           result = RW'(in1 / in2);
      end
    endcase
    if (div_by_zero) begin
      // Divide by zero shows F/F and is not reported as a zero result
      dec  = 4'hF;
      unis = 4'hF;
      zero = 1'b0;
    end else begin
      dec  = 4'((result / 10) % 10);
      unis = 4'(result % 10);
      zero = (result == '0);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one decimal ALU between NREQ requesters with round-robin grant,
// registered operands and a registered, handshaked response.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating op/error counters.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  input  logic [NREQ*WIDTH-1:0] req_in2,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [3:0]            rsp_dec,
  output logic [3:0]            rsp_unis,
  output logic                  rsp_zero,
  output logic                  rsp_error,
`ifdef ALU_ARB_STATS_EN
  output logic [STAT_W-1:0]     stat_ops,
  output logic [STAT_W-1:0]     stat_errs,
`endif
  output logic                  busy
);

  logic [1:0]       state_reg;
  logic [IDW-1:0]   last_grant_reg;
  logic [WIDTH-1:0] in1_reg;
  logic [WIDTH-1:0] in2_reg;
  logic [1:0]       op_reg;
  logic [IDW-1:0]   id_reg;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;

  logic [WIDTH-1:0] in1_arr [NREQ];
  logic [WIDTH-1:0] in2_arr [NREQ];
  logic [1:0]       op_arr  [NREQ];

  logic [3:0]       alu_dec_w;
  logic [3:0]       alu_unis_w;
  logic             alu_zero_w;
  logic             alu_error_w;

  logic             rsp_fire;

  // Unpack the flat requester buses into per-requester fields
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign in1_arr[gi] = req_in1[gi*WIDTH +: WIDTH];
      assign in2_arr[gi] = req_in2[gi*WIDTH +: WIDTH];
      assign op_arr[gi]  = req_op[gi*2 +: 2];
    end
  endgenerate

  alu_rr_grant #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_grant (
    .req_valid (req_valid),
    .last_grant(last_grant_reg),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  dec_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .in1  (in1_reg),
    .in2  (in2_reg),
    .op   (op_reg),
    .dec  (alu_dec_w),
    .unis (alu_unis_w),
    .zero (alu_zero_w),
    .error(alu_error_w)
  );

  // Accept only in IDLE, and only the round-robin winner
  assign req_ready = (state_reg == ST_IDLE) ? grant : '0;
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Arbiter FSM: capture operands, register ALU result, hold until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= IDW'(NREQ - 1);
      in1_reg        <= '0;
      in2_reg        <= '0;
      op_reg         <= '0;
      id_reg         <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_dec        <= '0;
      rsp_unis       <= '0;
      rsp_zero       <= 1'b0;
      rsp_error      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            in1_reg        <= in1_arr[grant_id];
            in2_reg        <= in2_arr[grant_id];
            op_reg         <= op_arr[grant_id];
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            state_reg      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_dec   <= alu_dec_w;
          rsp_unis  <= alu_unis_w;
          rsp_zero  <= alu_zero_w;
          rsp_error <= alu_error_w;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          // Data registers keep their value after the handshake
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating counters of consumed responses and of consumed errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_fire) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 1'b1;
      if (rsp_error && (stat_errs != '1)) stat_errs <= stat_errs + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (WIDTH=3, NREQ=4).
module tb_alu_share_arbiter;

  localparam int WIDTH = 3;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [3:0]            rsp_dec;
  logic [3:0]            rsp_unis;
  logic                  rsp_zero;
  logic                  rsp_error;
  logic                  busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0]            stat_ops;
  logic [7:0]            stat_errs;
`endif

  int vectors = 0;
  int errors  = 0;

  alu_share_arbiter #(
    .WIDTH(WIDTH),
    .NREQ (NREQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_in1  (req_in1),
    .req_in2  (req_in2),
    .req_op   (req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_dec  (rsp_dec),
    .rsp_unis (rsp_unis),
    .rsp_zero (rsp_zero),
    .rsp_error(rsp_error),
`ifdef ALU_ARB_STATS_EN
    .stat_ops (stat_ops),
    .stat_errs(stat_errs),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load operands/opcode for one requester (no valid change)
  task automatic set_req(input int idx, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] op);
    req_in1[idx*WIDTH +: WIDTH] = a;
    req_in2[idx*WIDTH +: WIDTH] = b;
    req_op[idx*2 +: 2]          = op;
  endtask

  // Issue one request from idx; returns at the negedge where the response is up
  task automatic issue(input int idx, input logic [2:0] a, input logic [2:0] b,
                       input logic [1:0] op);
    @(negedge clk);
    set_req(idx, a, b, op);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_in1 = '0;
    req_in2 = '0;
    req_op = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b id=%0d dec=%h unis=%h z=%b e=%b busy=%b rdy=%b, want all 0",
               rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error, busy, req_ready);
    end
`ifdef ALU_ARB_STATS_EN
    vectors++;
    if (stat_ops !== 8'd0 || stat_errs !== 8'd0) begin
      errors++;
      $display("FAIL reset_stats: got ops=%0d errs=%0d, want 0/0", stat_ops, stat_errs);
    end
`endif
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 3'd7, 3'd6, 2'b00);
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b, want 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_exec: got valid=%b busy=%b rdy=%b, want 0/1/0000", rsp_valid, busy, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error} !== {1'b1, 2'd0, 4'd1, 4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d %h%h z=%b e=%b, want v=1 id=0 13 z=0 e=0",
               rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got valid=%b busy=%b, want 0/0", rsp_valid, busy);
    end
    $display("single: req0 7+6 -> id=%0d %h%h", rsp_id, rsp_dec, rsp_unis);
  endtask

  task automatic test_mul_sub();
    issue(2, 3'd7, 3'd7, 2'b10);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error} !== {1'b1, 2'd2, 4'd4, 4'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_rsp: got v=%b id=%0d %h%h z=%b e=%b, want v=1 id=2 49 z=0 e=0",
               rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error);
    end
    $display("mul: req2 7*7 -> id=%0d %h%h", rsp_id, rsp_dec, rsp_unis);
    @(posedge clk);
    issue(1, 3'd2, 3'd5, 2'b01);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error} !== {1'b1, 2'd1, 4'd0, 4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_rsp: got v=%b id=%0d %h%h z=%b e=%b, want v=1 id=1 00 z=1 e=1",
               rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error);
    end
    $display("sub: req1 2-5 -> id=%0d e=%b", rsp_id, rsp_error);
    @(posedge clk);
  endtask

  task automatic test_div();
    issue(3, 3'd5, 3'd0, 2'b11);
    vectors++;
    if ({rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error} !== {2'd3, 4'hF, 4'hF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL div0_rsp: got id=%0d %h%h z=%b e=%b, want id=3 FF z=0 e=1",
               rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error);
    end
    $display("div: req3 5/0 -> %h%h e=%b", rsp_dec, rsp_unis, rsp_error);
    @(posedge clk);
    issue(3, 3'd6, 3'd3, 2'b11);
    vectors++;
    if ({rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error} !== {2'd3, 4'd0, 4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL div_rsp: got id=%0d %h%h z=%b e=%b, want id=3 02 z=0 e=0",
               rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error);
    end
    $display("div: req3 6/3 -> %h%h e=%b", rsp_dec, rsp_unis, rsp_error);
    @(posedge clk);
  endtask

  // last_grant is 3 on entry, so the rotation starts at requester 0
  task automatic test_rr();
    logic [3:0] exp_d [4];
    logic [3:0] exp_u [4];
    exp_d = '{4'd0, 4'd0, 4'd1, 4'd0};
    exp_u = '{4'd3, 4'd4, 4'd5, 4'd3};
    @(negedge clk);
    set_req(0, 3'd1, 3'd2, 2'b00);
    set_req(1, 3'd7, 3'd3, 2'b01);
    set_req(2, 3'd3, 3'd5, 2'b10);
    set_req(3, 3'd7, 3'd2, 2'b11);
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int g;
      g = n % 4;
      #1;
      vectors++;
      if (req_ready !== (4'b0001 << g)) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b, want %b", n, req_ready, 4'b0001 << g);
      end
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || rsp_dec !== exp_d[g] || rsp_unis !== exp_u[g]) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: got v=%b id=%0d %h%h, want v=1 id=%0d %h%h",
                 n, rsp_valid, rsp_id, rsp_dec, rsp_unis, g, exp_d[g], exp_u[g]);
      end
      $display("rr: grant %0d -> id=%0d %h%h", n, rsp_id, rsp_dec, rsp_unis);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  // last_grant is 1 on entry
  task automatic test_hold();
    rsp_ready = 1'b0;
    issue(0, 3'd4, 3'd4, 2'b00);
    req_valid = 4'b0010;
    set_req(1, 3'd1, 3'd1, 2'b00);
    for (int n = 0; n < 5; n++) begin
      vectors++;
      if ({rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error, busy, req_ready} !==
          {1'b1, 2'd0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1, 4'b0000}) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b id=%0d %h%h z=%b e=%b busy=%b rdy=%b, want v=1 id=0 08 z=0 e=0 busy=1 rdy=0000",
                 n, rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error, busy, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0010 || rsp_unis !== 4'd8) begin
      errors++;
      $display("FAIL hold_release: got v=%b busy=%b rdy=%b unis=%h, want 0/0/0010/8",
               rsp_valid, busy, req_ready, rsp_unis);
    end
    // Requester 1 withdraws before being granted
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_withdraw: got busy=%b v=%b, want 0/0", busy, rsp_valid);
    end
    $display("hold: response held 5 cycles then consumed");
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    set_req(1, 3'd6, 3'd1, 2'b01);
    req_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL rst_exec: got v=%b id=%0d %h%h z=%b e=%b busy=%b rdy=%b, want all 0",
               rsp_valid, rsp_id, rsp_dec, rsp_unis, rsp_zero, rsp_error, busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rsp: got v=%b busy=%b, want 0/0", rsp_valid, busy);
    end
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_priority: got %b, want 0001", req_ready);
    end
    req_valid = '0;
    $display("reset_exec: aborted, next grant req_ready=%b", req_ready);
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    for (int n = 0; n < 300; n++) begin
      issue(2, 3'd3, 3'd0, 2'b11);
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (stat_errs !== 8'd255 || stat_ops !== 8'd255) begin
      errors++;
      $display("FAIL stats_sat: got ops=%0d errs=%0d, want 255/255", stat_ops, stat_errs);
    end
    $display("stats: ops=%0d errs=%0d", stat_ops, stat_errs);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_mul_sub();
    test_div();
    test_rr();
    test_hold();
    test_reset_exec();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
